// File: rtl/alu_seq.sv
// alu_seq: sequential MIPS32 execute unit.
// One operation is accepted at a time over a valid/ready handshake.
// Logic and arithmetic ops finish in one cycle. Shifts run one bit per cycle.
// The result is held until the consumer takes it.
//
// Handshake: an input transfer happens on a rising edge where
// in_valid & in_ready. An output transfer happens on a rising edge where
// out_valid & out_ready. Neither side may retract an offered item before
// its transfer. in_valid is ignored while in_ready is low.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // Shift kind: ctrl[1:0] of a shift code (00 sll, 01 srl, 10 sra).
  logic [1:0]       kind_q, kind_d;

  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] one_cycle_res;
  logic [WIDTH-1:0] sreg_step;

  assign accept   = in_valid & in_ready_q;
  assign is_shift = (ctrl == 4'b0000) || (ctrl == 4'b0001) || (ctrl == 4'b0010);

  // Result of every op that completes on the accept edge. A shift code
  // only reaches this path with shamt == 0, so its result is b.
  always_comb begin
    one_cycle_res = '0;
    case (ctrl)
      4'b0000, 4'b0001, 4'b0010: one_cycle_res = b;
      4'b0011: one_cycle_res = a + b;
      4'b0100: one_cycle_res = a - b;
      4'b0101: one_cycle_res = a & b;
      4'b0110: one_cycle_res = a | b;
      4'b0111: one_cycle_res = a ^ b;
      4'b1000: one_cycle_res = ~(a | b);
      4'b1001: one_cycle_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1010: one_cycle_res = {b[15:0], {(WIDTH-16){1'b0}}};
      default: one_cycle_res = '0;
    endcase
  end

  // One-bit step of the shift register in the latched direction and type.
  always_comb begin
    sreg_step = sreg_q;
    case (kind_q)
      2'b00:   sreg_step = {sreg_q[WIDTH-2:0], 1'b0};
      2'b01:   sreg_step = {1'b0, sreg_q[WIDTH-1:1]};
      2'b10:   sreg_step = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      default: sreg_step = sreg_q;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/SHIFT/DONE FSM.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          in_ready_d = 1'b0;
          if (is_shift && (shamt != '0)) begin
            sreg_d  = b;
            cnt_d   = shamt;
            kind_d  = ctrl[1:0];
            state_d = S_SHIFT;
          end else begin
            result_d    = one_cycle_res;
            zero_d      = (one_cycle_res == '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_step;
        cnt_d  = cnt_q - 1'b1;
        // The last step lands directly in the result register.
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          result_d    = sreg_step;
          zero_d      = (sreg_step == '0);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset wins over any simultaneous handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      sreg_q      <= '0;
      cnt_q       <= '0;
      kind_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, hand-written corner sequences and
// random ops checked against a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W), .SHW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: results straight from the operation table.
  function automatic logic [W-1:0] model_res(input logic [3:0] c, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic [4:0] sh);
    case (c)
      4'd0:    return y << sh;
      4'd1:    return y >> sh;
      4'd2:    return W'($signed(y) >>> sh);
      4'd3:    return x + y;
      4'd4:    return x - y;
      4'd5:    return x & y;
      4'd6:    return x | y;
      4'd7:    return x ^ y;
      4'd8:    return ~(x | y);
      4'd9:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd10:   return y * 32'h0001_0000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [4:0] sh);
    if (c <= 4'd2 && sh != 5'd0) return int'(sh) + 1;
    return 1;
  endfunction

  // ---------------- driver ----------------
  // Offers one op, waits for acceptance, measures the latency in cycles
  // from the accept edge to out_valid, then takes the result.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [4:0] sh, output logic [W-1:0] r, output logic z,
                        output int lat);
    int waitc;
    @(negedge clk);
    in_valid = 1'b1; ctrl = c; a = x; b = y; shamt = sh; out_ready = 1'b0;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: out_valid stayed 0");
    end
    r = result;
    z = zero;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [4:0]   sh;
    logic [W-1:0] er;
    logic         ez;
    int           el;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           seen_valid;
    logic [3:0]   rc;
    logic [W-1:0] ra, rb;
    logic [4:0]   rs;

    // Vector table: ctrl, a, b, shamt, result, zero, latency.
    vecs[0]  = '{4'd3,  32'd5,         32'd7,         5'd0,  32'd12,        1'b0, 1};
    vecs[1]  = '{4'd3,  32'hFFFFFFFF,  32'd1,         5'd0,  32'd0,         1'b1, 1};
    vecs[2]  = '{4'd4,  32'd3,         32'd5,         5'd0,  32'hFFFFFFFE,  1'b0, 1};
    vecs[3]  = '{4'd9,  32'h80000000,  32'd1,         5'd0,  32'd1,         1'b0, 1};
    vecs[4]  = '{4'd9,  32'd1,         32'h80000000,  5'd0,  32'd0,         1'b1, 1};
    vecs[5]  = '{4'd0,  32'd0,         32'd1,         5'd31, 32'h80000000,  1'b0, 32};
    vecs[6]  = '{4'd2,  32'd0,         32'h80000000,  5'd4,  32'hF8000000,  1'b0, 5};
    vecs[7]  = '{4'd1,  32'd0,         32'h80000000,  5'd4,  32'h08000000,  1'b0, 5};
    vecs[8]  = '{4'd0,  32'd0,         32'h12345678,  5'd0,  32'h12345678,  1'b0, 1};
    vecs[9]  = '{4'd5,  32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'hF000F000,  1'b0, 1};
    vecs[10] = '{4'd6,  32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'hFFF0FFF0,  1'b0, 1};
    vecs[11] = '{4'd7,  32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'h0FF00FF0,  1'b0, 1};
    vecs[12] = '{4'd8,  32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'h000F000F,  1'b0, 1};
    vecs[13] = '{4'd10, 32'd0,         32'h00001234,  5'd0,  32'h12340000,  1'b0, 1};
    vecs[14] = '{4'd15, 32'd5,         32'd7,         5'd3,  32'd0,         1'b1, 1};
    vecs[15] = '{4'd9,  32'hFFFFFFFF,  32'd0,         5'd0,  32'd1,         1'b0, 1};
    vecs[16] = '{4'd2,  32'd0,         32'h80000001,  5'd0,  32'h80000001,  1'b0, 1};

    // ---------------- reset ----------------
    reset = 1'b1; in_valid = 1'b0; ctrl = '0; a = '0; b = '0; shamt = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready",  W'(in_ready),  32'd1);
    check("rst_out_valid", W'(out_valid), 32'd0);
    check("rst_result",    result,        32'd0);
    check("rst_zero",      W'(zero),      32'd0);

    // ---------------- directed table ----------------
    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].c, vecs[i].x, vecs[i].y, vecs[i].sh, r, z, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].er);
      check($sformatf("vec%0d_zero", i), W'(z), W'(vecs[i].ez));
      check($sformatf("vec%0d_latency", i), W'(lat), W'(vecs[i].el));
      check($sformatf("vec%0d_in_ready_after", i), W'(in_ready), 32'd1);
      check($sformatf("vec%0d_out_valid_after", i), W'(out_valid), 32'd0);
    end

    // ---------------- backpressure ----------------
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd3; a = 32'd1; b = 32'd2; shamt = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Keep offering a different op while the result is parked.
    ctrl = 4'd4; a = 32'd100; b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_out_valid", k), W'(out_valid), 32'd1);
      check($sformatf("bp%0d_result", k), result, 32'd3);
      check($sformatf("bp%0d_in_ready", k), W'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_done_out_valid", W'(out_valid), 32'd0);
    check("bp_done_in_ready",  W'(in_ready),  32'd1);
    check("bp_held_result",    result,        32'd3);
    repeat (3) @(negedge clk);
    check("bp_single_completion", W'(out_valid), 32'd0);

    // ---------------- reset mid-shift ----------------
    @(negedge clk);
    in_valid = 1'b1; ctrl = 4'd0; a = '0; b = 32'd1; shamt = 5'd20; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_in_ready",  W'(in_ready),  32'd1);
    check("rst_mid_out_valid", W'(out_valid), 32'd0);
    check("rst_mid_result",    result,        32'd0);
    for (int k = 0; k < 30; k++) begin
      if (out_valid) seen_valid++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("rst_mid_no_valid", W'(seen_valid), 32'd0);
    run_op(4'd3, 32'd40, 32'd2, 5'd0, r, z, lat);
    check("post_rst_result",  r,        32'd42);
    check("post_rst_latency", W'(lat),  32'd1);

    // ---------------- random ops vs model ----------------
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rs = 5'($urandom_range(0, 31));
      exp_q.push_back(model_res(rc, ra, rb, rs));
      run_op(rc, ra, rb, rs, r, z, lat);
      begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check($sformatf("rnd%0d_c%0d_result", i, rc), r, e);
        check($sformatf("rnd%0d_zero", i), W'(z), W'(e == '0));
        check($sformatf("rnd%0d_latency", i), W'(lat), W'(model_lat(rc, rs)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
